// File: rtl/eq_monitor.sv
// Golden/revised output cross-check over a programmed sample window.
// Counts mismatches, tracks first mismatch index, reports pass/fail.
module eq_monitor #(
  parameter int CNT_W  = 16,
  parameter int WARMUP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             vld,
  input  logic             x_gld,
  input  logic             x_rvs,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] mis_cnt,
  output logic [CNT_W-1:0] first_idx,
  output logic             first_vld
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WARM = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [CNT_W-1:0] ONES  = '1;
  localparam logic [CNT_W-1:0] WLAST =
    CNT_W'(WARMUP > 0 ? WARMUP - 1 : 0);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_mis;
  logic [CNT_W-1:0] r_fidx;
  logic             r_fvld;
  logic             r_fail;

  logic             w_mis;
  logic             w_last;
  logic             w_wlast;

  assign w_mis   = x_gld != x_rvs;
  assign w_last  = r_idx == (r_len - CNT_W'(1));
  assign w_wlast = r_wcnt == WLAST;

  // Window FSM with mismatch bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_wcnt  <= '0;
      r_idx   <= '0;
      r_mis   <= '0;
      r_fidx  <= '0;
      r_fvld  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_len  <= len;
            r_wcnt <= '0;
            r_idx  <= '0;
            r_mis  <= '0;
            r_fidx <= '0;
            r_fvld <= 1'b0;
            r_fail <= 1'b0;
            if (len == '0)
              r_state <= DONE;
            else if (WARMUP > 0)
              r_state <= WARM;
            else
              r_state <= RUN;
          end
        end
        WARM: begin
          if (vld) begin
            if (w_wlast)
              r_state <= RUN;
            else
              r_wcnt <= r_wcnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (vld) begin
            if (w_mis) begin
              r_fail <= 1'b1;
              if (r_mis != ONES)
                r_mis <= r_mis + CNT_W'(1);
              if (!r_fvld) begin
                r_fidx <= r_idx;
                r_fvld <= 1'b1;
              end
            end
            if (w_last)
              r_state <= DONE;
            else
              r_idx <= r_idx + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = (r_state == WARM) || (r_state == RUN);
  assign done      = r_state == DONE;
  assign fail      = r_fail;
  assign mis_cnt   = r_mis;
  assign first_idx = r_fidx;
  assign first_vld = r_fvld;

endmodule

// File: tb/tb_eq_monitor.sv
// Directed bench for eq_monitor with a result scoreboard.
// Expected window results are queued at start and popped at done.
module tb_eq_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 0, vld = 0, xg = 0, xr = 0;
  logic [15:0] len = '0;
  logic        busy, done, fail, fvld;
  logic [15:0] mis, fidx;

  logic        s4 = 0, v4 = 0, g4 = 0, r4 = 0;
  logic [3:0]  l4 = '0;
  logic        busy4, done4, fail4, fvld4;
  logic [3:0]  mis4, fidx4;

  eq_monitor #(.CNT_W(16), .WARMUP(1)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .vld(vld), .x_gld(xg), .x_rvs(xr), .busy(busy),
    .done(done), .fail(fail), .mis_cnt(mis),
    .first_idx(fidx), .first_vld(fvld)
  );

  eq_monitor #(.CNT_W(4), .WARMUP(1)) u4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .len(l4),
    .vld(v4), .x_gld(g4), .x_rvs(r4), .busy(busy4),
    .done(done4), .fail(fail4), .mis_cnt(mis4),
    .first_idx(fidx4), .first_vld(fvld4)
  );

  typedef struct packed {
    logic [15:0] mis;
    logic [15:0] fidx;
    logic        fv;
    logic        fl;
  } res_t;

  res_t sb[$];
  int ncmp = 0;
  int nerr = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic g, logic r);
    vld = 1; xg = g; xr = r;
    tick();
    vld = 0; xg = 0; xr = 0;
  endtask

  task automatic gap();
    vld = 0;
    tick();
  endtask

  task automatic go(logic [15:0] n, res_t e);
    sb.push_back(e);
    start = 1; len = n;
    tick();
    start = 0;
  endtask

  task automatic pop_cmp(string tag, logic [15:0] m,
                         logic [15:0] fi, logic fv, logic fl);
    res_t e;
    if (sb.size() == 0) begin
      ncmp++;
      nerr++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".mis"},  32'(m),  32'(e.mis));
      chk({tag, ".fidx"}, 32'(fi), 32'(e.fidx));
      chk({tag, ".fvld"}, 32'(fv), 32'(e.fv));
      chk({tag, ".fail"}, 32'(fl), 32'(e.fl));
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.mis",  32'(mis),  0);
    rst_n = 1;
    tick();

    // len 0: straight to done
    go(16'd0, '{mis: 0, fidx: 0, fv: 0, fl: 0});
    chk("t4.done", 32'(done), 1);
    chk("t4.busy", 32'(busy), 0);
    pop_cmp("t4", mis, fidx, fvld, fail);

    // len 4, clean window
    go(16'd4, '{mis: 0, fidx: 0, fv: 0, fl: 0});
    chk("t1.busy", 32'(busy), 1);
    chk("t1.done0", 32'(done), 0);
    for (int i = 0; i < 4; i++) send(1, 1);
    chk("t1.early", 32'(done), 0);
    send(0, 0);
    chk("t1.done", 32'(done), 1);
    chk("t1.busy0", 32'(busy), 0);
    pop_cmp("t1", mis, fidx, fvld, fail);

    // len 8, mismatches at run idx 2 and 5
    go(16'd8, '{mis: 2, fidx: 2, fv: 1, fl: 1});
    send(1, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("t2.early", 32'(done), 0);
      send(1, (i == 2 || i == 5) ? 1'b0 : 1'b1);
    end
    chk("t2.done", 32'(done), 1);
    pop_cmp("t2", mis, fidx, fvld, fail);

    // len 3 with vld gaps
    go(16'd3, '{mis: 0, fidx: 0, fv: 0, fl: 0});
    send(0, 0);
    gap();
    gap();
    chk("t3.busyg", 32'(busy), 1);
    send(1, 1);
    gap();
    chk("t3.busyg2", 32'(busy), 1);
    send(0, 0);
    chk("t3.early", 32'(done), 0);
    send(1, 1);
    chk("t3.done", 32'(done), 1);
    pop_cmp("t3", mis, fidx, fvld, fail);

    // CNT_W=4, len 15, every sample mismatched
    sb.push_back('{mis: 15, fidx: 0, fv: 1, fl: 1});
    s4 = 1; l4 = 4'd15;
    tick();
    s4 = 0;
    v4 = 1;
    for (int i = 0; i < 16; i++) begin
      g4 = 1; r4 = 0;
      tick();
    end
    v4 = 0;
    chk("t5.done", 32'(done4), 1);
    pop_cmp("t5", 16'(mis4), 16'(fidx4), fvld4, fail4);

    // async reset mid-run, then a clean restart
    go(16'd8, '{mis: 0, fidx: 0, fv: 0, fl: 0});
    send(0, 0);
    for (int i = 0; i < 3; i++) send(1, 0);
    chk("t6.mis3", 32'(mis), 3);
    #2;
    rst_n = 0;
    #1;
    chk("t6.rbusy", 32'(busy), 0);
    chk("t6.rmis",  32'(mis),  0);
    chk("t6.rfail", 32'(fail), 0);
    chk("t6.rfvld", 32'(fvld), 0);
    void'(sb.pop_back());
    tick();
    rst_n = 1;
    tick();
    go(16'd2, '{mis: 1, fidx: 1, fv: 1, fl: 1});
    send(0, 0);
    start = 1; len = 16'd9;
    send(1, 1);
    start = 0;
    chk("t6.busy", 32'(busy), 1);
    send(1, 0);
    chk("t6.done", 32'(done), 1);
    pop_cmp("t6", mis, fidx, fvld, fail);
    chk("sb.empty", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
